// File: rtl/act_pkg.sv
// Shared types and constant helpers for the multi-lane activation unit.
package act_pkg;

    // Runtime activation select, travels down the pipe with its beat.
    typedef enum logic [1:0] {
        ACT_RELU   = 2'd0,
        ACT_RELU6  = 2'd1,
        ACT_HSIG   = 2'd2,
        ACT_HSWISH = 2'd3
    } act_mode_e;

    // 1.0 in Q(INT.FRAC).
    function automatic longint act_one(input int unsigned frac_bits);
        return longint'(1) << frac_bits;
    endfunction

    // 3.0 in Q(INT.FRAC).
    function automatic longint act_three(input int unsigned frac_bits);
        return 3 * act_one(frac_bits);
    endfunction

    // 6.0 in Q(INT.FRAC).
    function automatic longint act_six(input int unsigned frac_bits);
        return 6 * act_one(frac_bits);
    endfunction

    // round(2^FRAC / 6), the hard-sigmoid slope.
    function automatic longint act_c6(input int unsigned frac_bits);
        return (act_one(frac_bits) + 3) / 6;
    endfunction

    // Largest integer-valued positive sample: sign clear, integer ones, fraction zero.
    function automatic longint act_max_value(input int unsigned int_bits,
                                             input int unsigned frac_bits);
        return ((longint'(1) << (int_bits - 1)) - 1) << frac_bits;
    endfunction

endpackage

// File: rtl/act_lane.sv
// Single-lane 3-stage activation datapath.
// HSWISH_EN compiles in the hard-sigmoid / hard-swish multipliers; without it
// modes 2 and 3 fall back to the ReLU result.
module act_lane
    import act_pkg::*;
#(
    parameter int unsigned INT_BITS   = 16,
    parameter int unsigned FRAC_BITS  = 16,
    parameter int unsigned DATA_WIDTH = INT_BITS + FRAC_BITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stage_en,
    input  logic                  ld1,
    input  logic                  ld2,
    input  logic                  ld3,
    input  logic [1:0]            mode0,
`ifdef HSWISH_EN
    input  logic [1:0]            mode1,
    input  logic [1:0]            mode2,
`endif
    input  logic [DATA_WIDTH-1:0] x,
    output logic [DATA_WIDTH-1:0] y
);

    localparam int unsigned DW = DATA_WIDTH;
    localparam int unsigned EW = DATA_WIDTH + 1;
    localparam logic signed [EW-1:0] MAX_E = EW'(act_max_value(INT_BITS, FRAC_BITS));
    localparam logic signed [EW-1:0] SIX_E = EW'(act_six(FRAC_BITS));
`ifdef HSWISH_EN
    localparam int unsigned PW = 2 * DATA_WIDTH;
    localparam logic signed [EW-1:0] THREE_E = EW'(act_three(FRAC_BITS));
    localparam logic signed [PW-1:0] ONE_P   = PW'(act_one(FRAC_BITS));
    localparam logic signed [PW-1:0] C6_P    = PW'(act_c6(FRAC_BITS));
    localparam logic signed [PW-1:0] MAX_P   = PW'(act_max_value(INT_BITS, FRAC_BITS));
    localparam logic signed [PW-1:0] MIN_P   = -(MAX_P + ONE_P);
    localparam logic signed [DW-1:0] ONE_D   = DW'(ONE_P);
    localparam logic signed [DW-1:0] MAX_D   = DW'(MAX_P);
    localparam logic signed [DW-1:0] MIN_D   = DW'(MIN_P);
`endif

    logic signed [DW-1:0] x_s;
    logic signed [EW-1:0] x_e;
    logic signed [EW-1:0] relu_e;
    logic signed [EW-1:0] relu6_e;
    logic signed [DW-1:0] c1_d;
    logic signed [DW-1:0] c1_q;
    logic signed [DW-1:0] p2_d;
    logic signed [DW-1:0] p2_q;
    logic signed [DW-1:0] y3_d;
    logic signed [DW-1:0] y3_q;
    act_mode_e            m0;
`ifdef HSWISH_EN
    logic signed [EW-1:0] off_e;
    logic signed [EW-1:0] r_e;
    logic signed [DW-1:0] x1_q;
    logic signed [DW-1:0] x2_q;
    logic signed [PW-1:0] h_prod;
    logic signed [PW-1:0] h_shift;
    logic signed [DW-1:0] h_val;
    logic signed [PW-1:0] y_prod;
    logic signed [PW-1:0] y_shift;
    logic signed [DW-1:0] y_sat;
`endif

    assign x_s = signed'(x);
    assign x_e = EW'(x_s);
    assign m0  = act_mode_e'(mode0);
    assign y   = y3_q;

    // S1 compute: ReLU / ReLU6 clamps, or the offset clamp feeding hard-sigmoid.
    always_comb begin
        relu_e = x_e;
        if (x_s[DW-1]) begin
            relu_e = '0;
        end else if (x_e > MAX_E) begin
            relu_e = MAX_E;
        end
        relu6_e = x_e;
        if (x_s[DW-1]) begin
            relu6_e = '0;
        end else if (x_e > SIX_E) begin
            relu6_e = SIX_E;
        end
`ifdef HSWISH_EN
        off_e = x_e + THREE_E;
        r_e   = off_e;
        if (off_e[EW-1]) begin
            r_e = '0;
        end else if (off_e > SIX_E) begin
            r_e = SIX_E;
        end
`endif
        c1_d = DW'(relu_e);
        case (m0)
            ACT_RELU6: c1_d = DW'(relu6_e);
`ifdef HSWISH_EN
            ACT_HSIG, ACT_HSWISH: c1_d = DW'(r_e);
`endif
            default: ;
        endcase
    end

    // S1 registers; x rides along for the hard-swish product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c1_q <= '0;
`ifdef HSWISH_EN
            x1_q <= '0;
`endif
        end else if (stage_en && ld1) begin
            c1_q <= c1_d;
`ifdef HSWISH_EN
            x1_q <= x_s;
`endif
        end
    end

    // S2 compute: h = min((r*C6)>>>FRAC, ONE), or pass the clamped value through.
    always_comb begin
        p2_d = c1_q;
`ifdef HSWISH_EN
        h_prod  = PW'(c1_q) * C6_P;
        h_shift = h_prod >>> FRAC_BITS;
        h_val   = (h_shift > ONE_P) ? ONE_D : DW'(h_shift);
        if ((act_mode_e'(mode1) == ACT_HSIG) || (act_mode_e'(mode1) == ACT_HSWISH)) begin
            p2_d = h_val;
        end
`endif
    end

    // S2 registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p2_q <= '0;
`ifdef HSWISH_EN
            x2_q <= '0;
`endif
        end else if (stage_en && ld2) begin
            p2_q <= p2_d;
`ifdef HSWISH_EN
            x2_q <= x1_q;
`endif
        end
    end

    // S3 compute: hard-swish product with saturation, else pass through.
    always_comb begin
        y3_d = p2_q;
`ifdef HSWISH_EN
        y_prod  = PW'(x2_q) * PW'(p2_q);
        y_shift = y_prod >>> FRAC_BITS;
        y_sat   = DW'(y_shift);
        if (y_shift > MAX_P) begin
            y_sat = MAX_D;
        end else if (y_shift < MIN_P) begin
            y_sat = MIN_D;
        end
        if (act_mode_e'(mode2) == ACT_HSWISH) begin
            y3_d = y_sat;
        end
`endif
    end

    // S3 output register; holds across bubbles and stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y3_q <= '0;
        end else if (stage_en && ld3) begin
            y3_q <= y3_d;
        end
    end

endmodule

// File: rtl/activation_unit.sv
// Multi-lane pipelined activation unit (ReLU, ReLU6, hard-sigmoid, hard-swish).
// HSWISH_EN compiles in the hard-sigmoid / hard-swish datapath.
module activation_unit
    import act_pkg::*;
#(
    parameter int unsigned INT_BITS   = 16,
    parameter int unsigned FRAC_BITS  = 16,
    parameter int unsigned DATA_WIDTH = INT_BITS + FRAC_BITS,
    parameter int unsigned LANES      = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [1:0]                  mode,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES*DATA_WIDTH-1:0] data_in,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES*DATA_WIDTH-1:0] data_out
);

    logic v1;
    logic v2;
    logic v3;
    logic advance;
    logic accept;
`ifdef HSWISH_EN
    act_mode_e m1;
    act_mode_e m2;
`endif

    assign advance   = !v3 || out_ready;
    assign in_ready  = advance;
    assign accept    = in_valid && advance;
    assign out_valid = v3;

    // Valid pipeline: whole pipe advances together, bubbles are kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else if (advance) begin
            v1 <= accept;
            v2 <= v1;
            v3 <= v2;
        end
    end

`ifdef HSWISH_EN
    // Mode pipeline so each beat keeps the function it was accepted with.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m1 <= ACT_RELU;
            m2 <= ACT_RELU;
        end else begin
            if (accept) begin
                m1 <= act_mode_e'(mode);
            end
            if (advance && v1) begin
                m2 <= m1;
            end
        end
    end
`endif

    // One independent datapath per lane, lane 0 in the LSBs.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        act_lane #(
            .INT_BITS   (INT_BITS),
            .FRAC_BITS  (FRAC_BITS),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .stage_en (advance),
            .ld1      (in_valid),
            .ld2      (v1),
            .ld3      (v2),
            .mode0    (mode),
`ifdef HSWISH_EN
            .mode1    (m1),
            .mode2    (m2),
`endif
            .x        (data_in[g*DATA_WIDTH +: DATA_WIDTH]),
            .y        (data_out[g*DATA_WIDTH +: DATA_WIDTH])
        );
    end

endmodule

// File: tb/tb_activation_unit.sv
// Self-checking bench for activation_unit: directed cases plus randomized beats
// against an arithmetic reference model and a scoreboard with latency tracking.
module tb_activation_unit;

    localparam int unsigned LANES = 4;
    localparam int unsigned DW    = 32;
    localparam int unsigned BW    = LANES * DW;
    localparam longint ONE   = 65536;
    localparam longint THREE = 3 * ONE;
    localparam longint SIX   = 6 * ONE;
    localparam longint C6    = 10923;
    localparam longint MAXV  = 64'h7FFF_0000;
    localparam longint MINV  = -(MAXV + ONE);

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    mode;
    logic          in_valid;
    logic          in_ready;
    logic [BW-1:0] data_in;
    logic          out_valid;
    logic          out_ready;
    logic [BW-1:0] data_out;

    activation_unit #(
        .INT_BITS  (16),
        .FRAC_BITS (16),
        .LANES     (LANES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [BW-1:0] exp;
        int            acc_cyc;
        int            acc_stall;
    } beat_t;

    beat_t         sb[$];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            stalls = 0;
    logic [BW-1:0] exp_in = '0;
    logic          rand_ready = 1'b0;
    logic          bp_on = 1'b0;
    int            bp_start = 0;
    logic          prev_hold = 1'b0;
    logic [BW-1:0] prev_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference activation from plain integer arithmetic.
    function automatic longint act_ref(input longint x, input int m);
        longint r;
        longint h;
        longint yv;
        int     mm;
        mm = m;
`ifndef HSWISH_EN
        if (mm >= 2) mm = 0;
`endif
        case (mm)
            1: return (x < 0) ? 0 : ((x > SIX) ? SIX : x);
            2, 3: begin
                r = x + THREE;
                if (r < 0) r = 0;
                if (r > SIX) r = SIX;
                h = (r * C6) >>> 16;
                if (h > ONE) h = ONE;
                if (mm == 2) return h;
                yv = (x * h) >>> 16;
                if (yv > MAXV) yv = MAXV;
                if (yv < MINV) yv = MINV;
                return yv;
            end
            default: return (x < 0) ? 0 : ((x > MAXV) ? MAXV : x);
        endcase
    endfunction

    function automatic logic [BW-1:0] beat_ref(input logic [BW-1:0] d, input int m);
        logic [BW-1:0] o;
        logic [DW-1:0] lane;
        o = '0;
        for (int i = 0; i < LANES; i++) begin
            lane = d[i*DW +: DW];
            o[i*DW +: DW] = DW'(act_ref(longint'(signed'(lane)), m));
        end
        return o;
    endfunction

    function automatic logic [BW-1:0] pack4(input logic [DW-1:0] l0, input logic [DW-1:0] l1,
                                            input logic [DW-1:0] l2, input logic [DW-1:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    function automatic logic [DW-1:0] rnd_lane();
        case ($urandom_range(0, 2))
            0:       return DW'($urandom);
            1:       return DW'($urandom_range(0, 20 * 65536)) - DW'(10 * 65536);
            default: return 32'h7FFE_0000 + DW'($urandom_range(0, 3 * 65536));
        endcase
    endfunction

    // Output monitor: scoreboard, latency, hold-stability and handshake rule.
    task automatic monitor_step();
        beat_t b;
        beat_t nb;
        if (!rst_n) begin
            prev_hold = 1'b0;
            return;
        end
        if (prev_hold) begin
            chk("hold_valid", BW'(out_valid), BW'(1));
            chk("hold_data", data_out, prev_data);
        end
        chk("in_ready_rule", BW'(in_ready), BW'(!out_valid || out_ready));
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("spurious_out", BW'(out_valid), BW'(0));
            end else begin
                b = sb.pop_front();
                chk("data", data_out, b.exp);
                chk("latency", BW'(cyc), BW'(b.acc_cyc + 3 + stalls - b.acc_stall));
            end
        end
        if (in_valid && in_ready) begin
            nb.exp       = exp_in;
            nb.acc_cyc   = cyc;
            nb.acc_stall = stalls;
            sb.push_back(nb);
        end
        if (!in_ready) stalls++;
        prev_hold = out_valid && !out_ready;
        prev_data = data_out;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            monitor_step();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (bp_on) out_ready = !(((cyc - bp_start) >= 4) && ((cyc - bp_start) <= 7));
        else if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        else out_ready = 1'b1;
    endtask

    task automatic send(input logic [BW-1:0] d, input logic [1:0] m, input logic [BW-1:0] e);
        bit acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        data_in  = d;
        mode     = m;
        exp_in   = e;
        for (int n = 0; n < 64 && !acc; n++) begin
            @(negedge clk);
            acc = in_ready;
            tick();
        end
        if (!acc) chk("accept_timeout", BW'(acc), BW'(1));
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int n = 0; n < 100 && sb.size() != 0; n++) tick();
        if (sb.size() != 0) chk("drain_timeout", BW'(sb.size()), BW'(0));
    endtask

    logic [BW-1:0] d;
    logic [BW-1:0] hsw_beat;
    logic [1:0]    m;
    int            stalls0;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        mode      = 2'd0;
        data_in   = '0;
        out_ready = 1'b1;

        // Reset state.
        #2;
        chk("rst_out_valid", BW'(out_valid), BW'(0));
        chk("rst_data_out", data_out, BW'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1 chk("rst_in_ready", BW'(in_ready), BW'(1));

        // RELU sweep.
        send(pack4(32'hFFFF_0000, 32'h0002_8000, 32'h7FFF_FFFF, 32'h0),
             2'd0, pack4(32'h0, 32'h0002_8000, 32'h7FFF_0000, 32'h0));
        // RELU6.
        send(pack4(32'h0007_0000, 32'h0005_0000, 32'hFFFF_FFFF, 32'h0006_0000),
             2'd1, pack4(32'h0006_0000, 32'h0005_0000, 32'h0, 32'h0006_0000));
        // HSWISH and HSIG directed points.
`ifdef HSWISH_EN
        hsw_beat = pack4(32'h0000_AAAC, 32'h0, 32'h0005_0000, 32'h7FFF_0000);
        send(pack4(32'h0001_0000, 32'hFFFC_0000, 32'h0005_0000, 32'h7FFF_FFFF), 2'd3, hsw_beat);
        send(pack4(32'h0003_0000, 32'hFFFC_0000, 32'h0001_0000, 32'h0),
             2'd2, pack4(32'h0001_0000, 32'h0, 32'h0000_AAAC, 32'h0000_8001));
`else
        hsw_beat = pack4(32'h0001_0000, 32'h0, 32'h0005_0000, 32'h7FFF_0000);
        send(pack4(32'h0001_0000, 32'hFFFC_0000, 32'h0005_0000, 32'h7FFF_FFFF), 2'd3, hsw_beat);
        send(pack4(32'h0003_0000, 32'hFFFC_0000, 32'h0001_0000, 32'h0),
             2'd2, pack4(32'h0003_0000, 32'h0, 32'h0001_0000, 32'h0));
`endif
        drain();

        // Backpressure: 8 back-to-back beats, out_ready low for cycles 4..7.
        stalls0  = stalls;
        bp_start = cyc;
        bp_on    = 1'b1;
        for (int k = 0; k < 8; k++) begin
            d = pack4(DW'((k * 4 + 1) << 12), DW'((k * 4 + 2) << 12),
                      DW'((k * 4 + 3) << 12), DW'((k * 4 + 4) << 12));
            send(d, 2'd0, d);
        end
        drain();
        bp_on = 1'b0;
        chk("bp_in_ready_dropped", BW'(stalls > stalls0), BW'(1));

        // Mode switch every beat: RELU6 / HSWISH on x = 1.0.
        d = pack4(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000);
        for (int k = 0; k < 8; k++) begin
`ifdef HSWISH_EN
            send(d, (k % 2 == 0) ? 2'd1 : 2'd3,
                 (k % 2 == 0) ? d : pack4(32'h0000_AAAC, 32'h0000_AAAC, 32'h0000_AAAC, 32'h0000_AAAC));
`else
            send(d, (k % 2 == 0) ? 2'd1 : 2'd3, d);
`endif
        end
        drain();

        // Randomized beats with random bubbles and backpressure.
        rand_ready = 1'b1;
        for (int n = 0; n < 80; n++) begin
            m = 2'($urandom_range(0, 3));
            d = pack4(rnd_lane(), rnd_lane(), rnd_lane(), rnd_lane());
            send(d, m, beat_ref(d, int'(m)));
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        drain();
        rand_ready = 1'b0;
        idle(1);

        // Reset with three beats in flight.
        for (int k = 0; k < 3; k++) begin
            d = pack4(DW'((k + 1) << 16), DW'((k + 2) << 16), DW'((k + 3) << 16), DW'((k + 4) << 16));
            send(d, 2'd0, d);
        end
        in_valid = 1'b0;
        chk("pre_rst_valid", BW'(out_valid), BW'(1));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", BW'(out_valid), BW'(0));
        chk("mid_rst_data_out", data_out, BW'(0));
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1 chk("post_rst_in_ready", BW'(in_ready), BW'(1));
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("post_rst_no_out", BW'(out_valid), BW'(0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/activation_unit.md
# activation_unit

Multi-lane, pipelined fixed-point activation unit for the MobileNetV3 datapath, placed between the convolution/accumulator output and the feature-map write-back. Applies one of four runtime-selected activations (ReLU, ReLU6, hard-sigmoid, hard-swish) to LANES signed Q(INT_BITS.FRAC_BITS) samples per beat. Uses a 3-stage pipeline with valid/ready flow control on both sides. Successor to the single-lane, single-function, enable-only ReLU stage.

## Interface
- INT_BITS, 16, integer bits incl. sign
- FRAC_BITS, 16, fractional bits
- DATA_WIDTH, INT_BITS+FRAC_BITS, sample width
- LANES, 4, samples per beat
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- mode  in  2  activation select, sampled with the input beat: 0 RELU, 1 RELU6, 2 HSIG, 3 HSWISH
- in_valid  in  1  input beat valid
- in_ready  out  1  unit accepts the beat this cycle
- data_in  in  LANES*DATA_WIDTH  signed samples; lane 0 in LSBs
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts the output beat
- data_out  out  LANES*DATA_WIDTH  activated samples; same lane order

## Operation
- Constants, all Q(INT.FRAC):
  - ONE = 1<<FRAC_BITS
  - THREE = 3·ONE
  - SIX = 6·ONE
  - C6 = round(2^FRAC_BITS/6), 10923 at FRAC=16
  - MAX_VALUE = {0, INT_BITS-1 ones, FRAC_BITS zeros}
- Functions per lane, x signed:
  - RELU: x<0 → 0; x>MAX_VALUE → MAX_VALUE; else x.
  - RELU6: clamp(x, 0, SIX).
  - HSIG: r = clamp(x+THREE, 0, SIX), with the add at DATA_WIDTH+1 bits so it never wraps. h = (r·C6)>>>FRAC_BITS, then min(h, ONE).
  - HSWISH: y = (x·h)>>>FRAC_BITS, with the product at 2·DATA_WIDTH bits. Saturate to [-(MAX_VALUE+ONE), MAX_VALUE].
- Rounding: all right shifts truncate toward −∞; no rounding increment.
- Mode travels down the pipe with its beat. A mode change between beats takes effect on the next accepted beat; no flush.
- Lanes are fully independent and share the handshake and mode.

## Timing
- Pipeline stages:
  - S1 registers the clamp/offset.
  - S2 registers h (or the passed-through result for RELU/RELU6).
  - S3 registers the final value and saturation.
- Latency: exactly 3 cycles from acceptance to out_valid, absent stalls.
- Throughput: 1 beat/cycle.
- Flow control: advance = !v3 || out_ready.
  - When advance is high, every stage loads from its predecessor: v1←(in_valid && in_ready), v2←v1, v3←v2.
  - When advance is low, all stages hold.
  - in_ready = advance (combinational from out_ready and v3). Bubbles are not collapsed.
- A beat is accepted iff in_valid && in_ready. An output beat is consumed iff out_valid && out_ready.
- While out_valid && !out_ready, data_out holds stable.
- Stage data registers load only when the beat's valid bit is set, so data_out holds its last value across bubbles.
- Reset (async, any cycle):
  - v1..v3 = 0, data_out = 0, out_valid = 0.
  - in_ready = 1 in the first cycle after release.
  - In-flight beats are discarded; no partial output.

## Configuration
- HSWISH_EN defined: HSIG/HSWISH datapath, the multipliers, and C6 are compiled in.
- HSWISH_EN undefined:
  - Multipliers are removed. Modes 2 and 3 produce the RELU result.
  - Latency stays 3 cycles; the handshake is unchanged.

## Structure
- Package act_pkg holds:
  - the mode enum (ACT_RELU, ACT_RELU6, ACT_HSIG, ACT_HSWISH);
  - the functions computing ONE/THREE/SIX/C6/MAX_VALUE from INT_BITS/FRAC_BITS.
- Sub-module act_lane:
  - single-lane 3-stage datapath with a shared stage-enable input and a per-stage load qualifier;
  - instantiated LANES times by a generate loop.
- Top level owns the valid bits, mode pipeline, and handshake.

## Test plan
All values at FRAC=16, LANES=4, out_ready=1 unless stated.
- **RELU sweep:** lanes = {−0x0001_0000, 0x0002_8000, 0x7FFF_FFFF, 0}. Output 3 cycles later = {0, 0x0002_8000, 0x7FFF_0000, 0}.
- **RELU6:** lanes = {0x0007_0000, 0x0005_0000, −1, 0x0006_0000}. Output = {0x0006_0000, 0x0005_0000, 0, 0x0006_0000}.
- **HSIG/HSWISH (HSWISH_EN):**
  - HSWISH, x = 0x0001_0000 → 0x0000_AAAC.
  - HSWISH, x = −0x0004_0000 → 0.
  - HSWISH, x = 0x0005_0000 → 0x0005_0000.
  - HSIG, x = 0x0003_0000 → 0x0001_0000 (clamped from 65538).
- **Backpressure:**
  - Stream 8 beats with in_valid=1; hold out_ready=0 for cycles 4–7.
  - in_ready drops while v3 is stalled.
  - All 8 outputs arrive in order, none lost or duplicated, and data_out is stable during the stall.
- **Mode switch back-to-back:** beats alternate RELU6/HSWISH each cycle with x = 0x0001_0000. Outputs alternate 0x0001_0000 / 0x0000_AAAC.
- **Reset mid-stream:**
  - Assert rst_n low with 3 beats in flight → out_valid = 0 and data_out = 0 immediately.
  - After release: no stale beats emerge, and in_ready = 1.
